fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Fetch-to-decode instruction queue: replaces the single fetch/decode pipeline register with a
//  DEPTH-entry FIFO plus a registered decode output stage. The I-cache can keep fetching while
//  decode is stalled, and fetch is back-pressured only when the queue is full. A taken redirect
//  from execute flushes the whole queue and the output stage. Sits between fetch and decode.
// PARAMETERS
//  DATA_WIDTH    32            instruction width
//  ADDRESS_BITS  20            PC width
//  DEPTH         4             queue entries; power of 2, >= 2
//  NOP           32'h00000013  bubble instruction (addi x0,x0,0)
// PORTS
//  clock                   in   1             rising-edge clock
//  reset                   in   1             synchronous, active-high
//  stall                   in   1             decode stall: hold the output stage
//  inst_PC_fetch           in   ADDRESS_BITS  PC of the fetched word
//  instruction_fetch       in   DATA_WIDTH    fetched word
//  icache_valid            in   1             fetched word valid this cycle
//  next_PC_select_execute  in   2             execute PC-select code
//  branch_execute          in   1             branch taken in execute
//  fetch_ready             out  1             queue can accept a word (combinational from occupancy)
//  inst_PC_decode          out  ADDRESS_BITS  PC to decode (registered)
//  instruction_decode      out  DATA_WIDTH    instruction to decode (registered)
//  decode_valid            out  1             output stage holds a real instruction
//  occupancy               out  $clog2(DEPTH+1)  entries currently queued
// BEHAVIOUR
//  flush  = (sel==2'b11) | (sel==2'b10) | ((sel==2'b01) & branch_execute).
//  push   = icache_valid & fetch_ready & ~flush.   fetch_ready = (occupancy != DEPTH).
//  Priority each cycle: reset > flush > stall > advance.
//  Reset: pointers 0, occupancy 0, inst_PC_decode 0, instruction_decode NOP, decode_valid 0.
//    fetch_ready is 1 after reset. Reset mid-operation discards all entries.
//  Flush: same end state as reset. The fetch word presented in the flush cycle is dropped.
//    Flush overrides stall.
//  Stall (no flush): output stage holds all values; push allowed; no pop.
//  Advance (no stall, no flush), output stage loads:
//   - queue non-empty: the head entry is popped into the output, decode_valid=1.
//     A simultaneous push appends at the tail.
//   - queue empty & icache_valid: bypass, fetch word goes straight to the output,
//     decode_valid=1, occupancy stays 0. Latency is 1 cycle, as in the plain pipeline register.
//   - queue empty & ~icache_valid: bubble, PC 0, NOP, decode_valid=0.
//  Strict program order: bypass is allowed only when the queue is empty.
//  Full: fetch_ready=0 and the word is not accepted. Fetch must hold its PC and re-present it.
//    A same-cycle pop does NOT enable the push.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//    occupancy = prev + push - pop, always within 0..DEPTH.
//  Queue storage is not reset (data-only). Only pointers, occupancy and the output stage reset.
// TESTING (DEPTH=4)
//  1 reset 2 cycles -> PC 0, instr 0x13, decode_valid 0, occupancy 0, fetch_ready 1.
//  2 no stall, PCs 0x0/0x4/0x8 valid on consecutive cycles -> each appears at decode 1 cycle
//    later, occupancy stays 0.
//  3 stall 6 cycles while fetch streams 0x10,0x14.. -> output held; occupancy 1,2,3,4,4;
//    fetch_ready 0 once full. Release stall -> 0x10..0x1C drain in order, then bypass resumes.
//  4 queue holds 3, sel=2'b10 with icache_valid=1 and stall=1 -> next cycle PC 0, NOP,
//    decode_valid 0, occupancy 0. Repeat with sel=2'b01, branch=0 -> no flush.
//  5 12 words, stall alternating 1/0 -> decode sees all 12 in order, none duplicated or lost
//    (pointer wrap).
//  6 reset asserted with occupancy 3 -> reset state next cycle; fetch resumes normally afterwards.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch-to-decode queue: DEPTH-entry FIFO feeding a registered decode stage, 1-cycle bypass when empty.
// Fetch sees fetch_ready low only when full; a taken redirect flushes queue and output stage.
module fetch_queue_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDRESS_BITS = 20,
    parameter int                    DEPTH        = 4,
    parameter logic [DATA_WIDTH-1:0] NOP          = 32'h00000013
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [ADDRESS_BITS-1:0]        inst_PC_fetch,
    input  logic [DATA_WIDTH-1:0]          instruction_fetch,
    input  logic                           icache_valid,
    input  logic [1:0]                     next_PC_select_execute,
    input  logic                           branch_execute,
    output logic                           fetch_ready,
    output logic [ADDRESS_BITS-1:0]        inst_PC_decode,
    output logic [DATA_WIDTH-1:0]          instruction_decode,
    output logic                           decode_valid,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [ADDRESS_BITS-1:0] r_pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]   r_inst_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [OCC_W-1:0]        r_occ;
    logic [ADDRESS_BITS-1:0] r_pc_dec;
    logic [DATA_WIDTH-1:0]   r_inst_dec;
    logic                    r_dec_vld;

    logic w_flush;
    logic w_empty;
    logic w_advance;
    logic w_pop;
    logic w_bypass;
    logic w_push;
    logic w_write;

    assign w_flush = (next_PC_select_execute == 2'b11) |
                     (next_PC_select_execute == 2'b10) |
                     ((next_PC_select_execute == 2'b01) & branch_execute);

    assign fetch_ready = (r_occ != OCC_W'(DEPTH));
    assign w_empty     = (r_occ == '0);
    assign w_advance   = ~w_flush & ~stall;
    assign w_pop       = w_advance & ~w_empty;
    assign w_bypass    = w_advance & w_empty & icache_valid;
    assign w_push      = icache_valid & fetch_ready & ~w_flush;
    // A bypassed word goes straight to the output stage and never occupies a slot
    assign w_write     = w_push & ~w_bypass;

    always_ff @(posedge clock) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_occ <= r_occ + OCC_W'(w_write) - OCC_W'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_write) begin
            r_pc_mem[r_wr_ptr]   <= inst_PC_fetch;
            r_inst_mem[r_wr_ptr] <= instruction_fetch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_flush) begin
            r_pc_dec   <= '0;
            r_inst_dec <= NOP;
            r_dec_vld  <= 1'b0;
        end else if (!stall) begin
            if (!w_empty) begin
                r_pc_dec   <= r_pc_mem[r_rd_ptr];
                r_inst_dec <= r_inst_mem[r_rd_ptr];
                r_dec_vld  <= 1'b1;
            end else if (icache_valid) begin
                r_pc_dec   <= inst_PC_fetch;
                r_inst_dec <= instruction_fetch;
                r_dec_vld  <= 1'b1;
            end else begin
                r_pc_dec   <= '0;
                r_inst_dec <= NOP;
                r_dec_vld  <= 1'b0;
            end
        end
    end

    assign inst_PC_decode     = r_pc_dec;
    assign instruction_decode = r_inst_dec;
    assign decode_valid       = r_dec_vld;
    assign occupancy          = r_occ;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed vector table plus an alternating-stall streaming sequence for the fetch queue.
module tb_fetch_queue_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [19:0] inst_PC_fetch;
    logic [31:0] instruction_fetch;
    logic        icache_valid;
    logic [1:0]  next_PC_select_execute;
    logic        branch_execute;
    logic        fetch_ready;
    logic [19:0] inst_PC_decode;
    logic [31:0] instruction_decode;
    logic        decode_valid;
    logic [2:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    fetch_queue_unit #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .DEPTH(4), .NOP(NOP)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .stall                  (stall),
        .inst_PC_fetch          (inst_PC_fetch),
        .instruction_fetch      (instruction_fetch),
        .icache_valid           (icache_valid),
        .next_PC_select_execute (next_PC_select_execute),
        .branch_execute         (branch_execute),
        .fetch_ready            (fetch_ready),
        .inst_PC_decode         (inst_PC_decode),
        .instruction_decode     (instruction_decode),
        .decode_valid           (decode_valid),
        .occupancy              (occupancy)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        vld;
        logic [1:0]  sel;
        logic        br;
        logic [19:0] pc;
        logic [19:0] e_pc;
        logic        e_v;
        logic [2:0]  e_occ;
        logic        e_rdy;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(input logic [19:0] pc);
        return {12'hA5C, pc};
    endfunction

    task automatic add(input logic rst, input logic stl, input logic vld, input logic [1:0] sel,
                       input logic br, input logic [19:0] pc, input logic [19:0] e_pc,
                       input logic e_v, input logic [2:0] e_occ, input logic e_rdy);
        vec_t v;
        v.rst = rst; v.stl = stl; v.vld = vld; v.sel = sel; v.br = br; v.pc = pc;
        v.e_pc = e_pc; v.e_v = e_v; v.e_occ = e_occ; v.e_rdy = e_rdy;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic vld, input logic [1:0] sel,
                         input logic br, input logic [19:0] pc);
        reset                  = rst;
        stall                  = stl;
        icache_valid           = vld;
        next_PC_select_execute = sel;
        branch_execute         = br;
        inst_PC_fetch          = pc;
        instruction_fetch      = mk(pc);
    endtask

    initial begin
        int sent;
        int got;
        int cyc;
        logic acc;
        logic stl;

        // rst stl vld sel br pc | exp pc v occ rdy
        add(1,0,0,2'b00,0,20'h0,  20'h0, 0,0,1);
        add(1,0,0,2'b00,0,20'h0,  20'h0, 0,0,1);
        add(0,0,1,2'b00,0,20'h0,  20'h0, 1,0,1);
        add(0,0,1,2'b00,0,20'h4,  20'h4, 1,0,1);
        add(0,0,1,2'b00,0,20'h8,  20'h8, 1,0,1);
        add(0,1,1,2'b00,0,20'h10, 20'h8, 1,1,1);
        add(0,1,1,2'b00,0,20'h14, 20'h8, 1,2,1);
        add(0,1,1,2'b00,0,20'h18, 20'h8, 1,3,1);
        add(0,1,1,2'b00,0,20'h1C, 20'h8, 1,4,0);
        add(0,1,1,2'b00,0,20'h20, 20'h8, 1,4,0);
        add(0,1,1,2'b00,0,20'h20, 20'h8, 1,4,0);
        add(0,0,1,2'b00,0,20'h20, 20'h10,1,3,1);
        add(0,0,0,2'b00,0,20'h0,  20'h14,1,2,1);
        add(0,0,1,2'b00,0,20'h20, 20'h18,1,2,1);
        add(0,0,0,2'b00,0,20'h0,  20'h1C,1,1,1);
        add(0,0,0,2'b00,0,20'h0,  20'h20,1,0,1);
        add(0,0,1,2'b00,0,20'h24, 20'h24,1,0,1);
        add(0,1,1,2'b00,0,20'h30, 20'h24,1,1,1);
        add(0,1,1,2'b00,0,20'h34, 20'h24,1,2,1);
        add(0,1,1,2'b00,0,20'h38, 20'h24,1,3,1);
        add(0,1,1,2'b10,0,20'h3C, 20'h0, 0,0,1);
        add(0,1,1,2'b00,0,20'h40, 20'h0, 0,1,1);
        add(0,1,1,2'b00,0,20'h44, 20'h0, 0,2,1);
        add(0,1,1,2'b00,0,20'h48, 20'h0, 0,3,1);
        add(0,1,1,2'b01,0,20'h4C, 20'h0, 0,4,0);
        add(0,0,1,2'b01,1,20'h50, 20'h0, 0,0,1);
        add(0,0,1,2'b00,0,20'h50, 20'h50,1,0,1);
        add(0,1,1,2'b00,0,20'h60, 20'h50,1,1,1);
        add(0,1,1,2'b00,0,20'h64, 20'h50,1,2,1);
        add(0,1,1,2'b00,0,20'h68, 20'h50,1,3,1);
        add(1,0,1,2'b00,0,20'h6C, 20'h0, 0,0,1);
        add(0,0,1,2'b00,0,20'h70, 20'h70,1,0,1);
        add(0,0,1,2'b11,0,20'h74, 20'h0, 0,0,1);
        add(0,0,0,2'b00,0,20'h0,  20'h0, 0,0,1);

        drive(1,0,0,2'b00,0,20'h0);
        @(negedge clock);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].stl, vq[i].vld, vq[i].sel, vq[i].br, vq[i].pc);
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("v%0d pc", i),    32'(inst_PC_decode), 32'(vq[i].e_pc));
            chk($sformatf("v%0d instr", i), instruction_decode,
                vq[i].e_v ? mk(vq[i].e_pc) : NOP);
            chk($sformatf("v%0d valid", i), 32'(decode_valid), 32'(vq[i].e_v));
            chk($sformatf("v%0d occ", i),   32'(occupancy),    32'(vq[i].e_occ));
            chk($sformatf("v%0d rdy", i),   32'(fetch_ready),  32'(vq[i].e_rdy));
        end

        // Streaming with stall toggling every cycle: queue fills, wraps, and drains in order
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 12 || got < 12) && cyc < 200) begin
            stl = (cyc % 2 == 0);
            drive(0, stl, sent < 12, 2'b00, 0, 20'h100 + 20'(sent * 4));
            #1;
            acc = icache_valid && fetch_ready;
            @(posedge clock);
            @(negedge clock);
            if (acc) sent++;
            if (!stl && decode_valid) begin
                if (got < 12) begin
                    chk($sformatf("wrap pc%0d", got), 32'(inst_PC_decode), 32'h100 + 32'(got * 4));
                    chk($sformatf("wrap instr%0d", got), instruction_decode,
                        mk(20'h100 + 20'(got * 4)));
                end else begin
                    chk("wrap extra word", 32'(inst_PC_decode), 32'hFFFFFFFF);
                end
                got++;
            end
            cyc++;
        end
        chk("wrap sent count", 32'(sent), 32'd12);
        chk("wrap got count",  32'(got),  32'd12);
        chk("wrap final occ",  32'(occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
